// File: rtl/nco_voice_scheduler.sv
// Time-multiplexes one shared wavetable lookup across eight NCO voices and
// sums their offset-binary samples into a signed mix once per sample strobe.
module nco_voice_scheduler #(
  parameter int VOICES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_ce,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_voice,
  input  logic [15:0]        cfg_inc,
  input  logic [6:0]         cfg_prog,
  input  logic               cfg_gate,
  output logic               cfg_ready,
  output logic               lu_ce,
  output logic [6:0]         lu_phase,
  output logic [6:0]         lu_program,
  input  logic [7:0]         lu_sample,
  output logic signed [10:0] mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               overrun,
  input  logic               overrun_clr
);

  // state   | meaning
  // IDLE    | waiting for sample_ce, config writes accepted
  // ISSUE0  | first lookup cycle, or one-cycle skip of an ungated voice
  // ISSUE1  | second lookup cycle, lookup inputs held
  // CAPTURE | lookup sample accumulated, phase advanced
  // DONE    | mix registered, mix_valid pulsed
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE0  = 3'd1;
  localparam logic [2:0] ISSUE1  = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]         state;
  logic [2:0]         vidx;
  logic [15:0]        phase [VOICES];
  logic [15:0]        inc   [VOICES];
  logic [6:0]         prog  [VOICES];
  logic [VOICES-1:0]  gate;
  logic signed [10:0] acc;

  logic               cur_gate;
  logic [15:0]        cur_phase;
  logic               last_voice;
  logic               lu_active;
  logic signed [8:0]  sample_off;

  assign cur_gate   = gate[vidx];
  assign cur_phase  = phase[vidx];
  assign last_voice = (vidx == 3'd7);
  assign sample_off = $signed({1'b0, lu_sample}) - 9'sd128;

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign lu_ce      = ((state == ISSUE0) && cur_gate) || (state == ISSUE1);
  // Phase/program stay on the bus through CAPTURE so the table sees stable inputs.
  assign lu_active  = lu_ce || (state == CAPTURE);
  assign lu_phase   = lu_active ? cur_phase[15:9] : 7'd0;
  assign lu_program = lu_active ? prog[vidx] : 7'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vidx      <= 3'd0;
      gate      <= '0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
        prog[i]  <= '0;
      end
    end else begin
      mix_valid <= 1'b0;

      if (sample_ce && (state != IDLE))
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      if (cfg_we && (state == IDLE)) begin
        inc[cfg_voice]  <= cfg_inc;
        prog[cfg_voice] <= cfg_prog;
        gate[cfg_voice] <= cfg_gate;
      end

      case (state)
        IDLE: begin
          if (sample_ce) begin
            acc   <= '0;
            vidx  <= 3'd0;
            state <= ISSUE0;
          end
        end
        ISSUE0: begin
          if (cur_gate) begin
            state <= ISSUE1;
          end else begin
            phase[vidx] <= '0;
            vidx        <= vidx + 3'd1;
            state       <= last_voice ? DONE : ISSUE0;
          end
        end
        ISSUE1: state <= CAPTURE;
        CAPTURE: begin
          acc         <= acc + {{2{sample_off[8]}}, sample_off};
          phase[vidx] <= cur_phase + inc[vidx];
          vidx        <= vidx + 3'd1;
          state       <= last_voice ? DONE : ISSUE0;
        end
        DONE: begin
          mix_out   <= acc;
          mix_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
